nrisc_ula_seq: RTL and testbench

- Next-generation NRISC ALU: width-parametrised, valid/ready handshaked, multi-cycle capable.
- Single-cycle ops: add, sub, and, or, xor, not, variable-amount shift/rotate.
- Iterative ops: unsigned multiply (shift-add) and unsigned divide (restoring).
- Sits between the register-file read stage and writeback; stalls the issue stage through `in_ready`.

---
 rtl/nrisc_ula_pkg.sv | 36 +++
 rtl/nrisc_ula_muldiv.sv | 84 ++++++++
 rtl/nrisc_ula_seq.sv | 200 ++++++++++++++++++++
 tb/tb_nrisc_ula_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_ula_pkg.sv
// Shared definitions for the NRISC sequential ALU: opcodes, FSM encoding, flag positions.
package nrisc_ula_pkg;

    // Opcode map
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_ROR = 4'b1101;
    localparam logic [3:0] OP_ROL = 4'b1110;

    // Top-level sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ula_state_t;

    // Bit positions inside ULA_flags = {V, N, Z, C}
    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    // MUL and DIV are the only opcodes that go through the iterative engine
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/nrisc_ula_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per clock.
// 'start' loads the operands; 'done' is high during the final step, and lo/hi carry
// the value that step produces, so the caller registers them on that same edge.
module nrisc_ula_muldiv #(
    parameter int TAM = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           op_div,
    input  logic [TAM-1:0] a,
    input  logic [TAM-1:0] b,
    output logic           done,
    output logic [TAM-1:0] lo,
    output logic [TAM-1:0] hi,
    output logic           dz
);

    localparam int CW = $clog2(TAM);

    logic [CW-1:0]  cnt;
    logic           running;
    logic           div_q;
    logic [TAM-1:0] b_q;
    logic [TAM-1:0] hi_q;
    logic [TAM-1:0] lo_q;
    logic [TAM-1:0] hi_n;
    logic [TAM-1:0] lo_n;
    logic [TAM:0]   mul_sum;
    logic [TAM:0]   div_shift;
    logic [TAM:0]   div_diff;

    // One iteration: multiply adds B when the multiplier LSB is set then shifts the pair right;
    // divide shifts the next dividend bit into the remainder and subtracts B if it fits.
    // With B=0 every trial subtraction fits, giving an all-ones quotient and remainder A.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[TAM-1]};
        div_diff  = div_shift - {1'b0, b_q};
        hi_n      = mul_sum[TAM:1];
        lo_n      = {mul_sum[0], lo_q[TAM-1:1]};
        if (div_q) begin
            if (!div_diff[TAM]) begin
                hi_n = div_diff[TAM-1:0];
                lo_n = {lo_q[TAM-2:0], 1'b1};
            end else begin
                hi_n = div_shift[TAM-1:0];
                lo_n = {lo_q[TAM-2:0], 1'b0};
            end
        end
    end

    // Operand load on start, then TAM iterations counted down to zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            running <= 1'b0;
            cnt     <= '0;
            div_q   <= 1'b0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CW'(TAM - 1);
            div_q   <= op_div;
            b_q     <= b;
            hi_q    <= '0;
            lo_q    <= a;
        end else if (running) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            cnt  <= cnt - CW'(1);
            if (cnt == '0) begin
                running <= 1'b0;
            end
        end
    end

    assign done = running && (cnt == '0);
    assign lo   = lo_n;
    assign hi   = hi_n;
    assign dz   = (b_q == '0);

endmodule

// File: rtl/nrisc_ula_seq.sv
// NRISC ALU with valid/ready handshake. Single-cycle ops finish on the accept edge;
// MUL/DIV are sequenced through the iterative engine. Results are held in DONE until taken.
//
// Handshake: an operation is accepted on a rising edge where in_valid & in_ready; a result
// is consumed on a rising edge where out_valid & out_ready. out_valid and the result
// registers stay stable until consumed; in DONE with out_ready=1 a new op may be accepted
// on the same edge that consumes the current result.
module nrisc_ula_seq
    import nrisc_ula_pkg::*;
#(
    parameter int TAM = 16,
    parameter int SHW = $clog2(TAM)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [TAM-1:0] ULA_A,
    input  logic [TAM-1:0] ULA_B,
    input  logic [3:0]     ULA_ctrl,
    output logic [TAM-1:0] ULA_OUT,
    output logic [TAM-1:0] ULA_OUT_HI,
    output logic [3:0]     ULA_flags,
    output logic           out_valid,
    input  logic           out_ready
);

    ula_state_t     state;
    ula_state_t     state_n;
    logic           accept;
    logic           iter_op;
    logic           eng_start;
    logic           eng_done;
    logic [TAM-1:0] eng_lo;
    logic [TAM-1:0] eng_hi;
    logic           eng_dz;
    logic           div_q;

    logic [SHW-1:0] shamt;
    logic [SHW-1:0] shamt_neg;
    logic [TAM:0]   add_ext;
    logic [TAM:0]   sub_ext;
    logic [TAM:0]   shl_ext;
    logic [TAM:0]   shr_ext;
    logic [TAM-1:0] ror_res;
    logic [TAM-1:0] rol_res;
    logic [TAM-1:0] sc_res;
    logic           sc_c;
    logic           sc_v;
    logic [3:0]     sc_flags;
    logic [3:0]     it_flags;

    // Single-cycle datapath: every op computed from the live operands, selected by opcode.
    // Rotates use the complementary shift (-n mod TAM), which also gives A back for n=0.
    always_comb begin
        shamt     = ULA_B[SHW-1:0];
        shamt_neg = '0 - shamt;
        add_ext   = {1'b0, ULA_A} + {1'b0, ULA_B};
        sub_ext   = {1'b0, ULA_A} - {1'b0, ULA_B};
        shl_ext   = {1'b0, ULA_A} << shamt;
        shr_ext   = {ULA_A, 1'b0} >> shamt;
        ror_res   = (ULA_A >> shamt) | (ULA_A << shamt_neg);
        rol_res   = (ULA_A << shamt) | (ULA_A >> shamt_neg);
        sc_res    = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        case (ULA_ctrl)
            OP_ADD: begin
                sc_res = add_ext[TAM-1:0];
                sc_c   = add_ext[TAM];
                sc_v   = (ULA_A[TAM-1] == ULA_B[TAM-1]) && (add_ext[TAM-1] != ULA_A[TAM-1]);
            end
            OP_SUB: begin
                sc_res = sub_ext[TAM-1:0];
                sc_c   = sub_ext[TAM];
                sc_v   = (ULA_A[TAM-1] != ULA_B[TAM-1]) && (sub_ext[TAM-1] != ULA_A[TAM-1]);
            end
            OP_AND: sc_res = ULA_A & ULA_B;
            OP_OR:  sc_res = ULA_A | ULA_B;
            OP_XOR: sc_res = ULA_A ^ ULA_B;
            OP_NOT: sc_res = ~ULA_A;
            OP_SHR: begin
                sc_res = shr_ext[TAM:1];
                sc_c   = shr_ext[0];
            end
            OP_SHL: begin
                sc_res = shl_ext[TAM-1:0];
                sc_c   = shl_ext[TAM];
            end
            OP_ROR: begin
                sc_res = ror_res;
                sc_c   = (shamt != '0) && ror_res[TAM-1];
            end
            OP_ROL: begin
                sc_res = rol_res;
                sc_c   = (shamt != '0) && rol_res[0];
            end
            default: begin
                sc_res = '0;
            end
        endcase
        sc_flags        = '0;
        sc_flags[FLG_C] = sc_c;
        sc_flags[FLG_Z] = (sc_res == '0);
        sc_flags[FLG_N] = sc_res[TAM-1];
        sc_flags[FLG_V] = sc_v;
    end

    // Flags for a finished MUL/DIV, derived from the engine's final step
    always_comb begin
        it_flags        = '0;
        it_flags[FLG_N] = eng_lo[TAM-1];
        if (div_q) begin
            it_flags[FLG_C] = eng_dz;
            it_flags[FLG_Z] = (eng_lo == '0);
        end else begin
            it_flags[FLG_C] = (eng_hi != '0);
            it_flags[FLG_Z] = (eng_lo == '0) && (eng_hi == '0);
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        iter_op   = is_iter_op(ULA_ctrl);
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_BUSY: begin
                if (eng_done) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        accept    = in_valid && in_ready;
        eng_start = accept && iter_op;
        if (accept) begin
            state_n = iter_op ? ST_BUSY : ST_DONE;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Result registers: single-cycle results on accept, MUL/DIV results on the engine's last step
    always_ff @(posedge clk) begin
        if (!rst) begin
            ULA_OUT    <= '0;
            ULA_OUT_HI <= '0;
            ULA_flags  <= '0;
            div_q      <= 1'b0;
        end else if (accept) begin
            div_q <= (ULA_ctrl == OP_DIV);
            if (!iter_op) begin
                ULA_OUT    <= sc_res;
                ULA_OUT_HI <= '0;
                ULA_flags  <= sc_flags;
            end
        end else if ((state == ST_BUSY) && eng_done) begin
            ULA_OUT    <= eng_lo;
            ULA_OUT_HI <= eng_hi;
            ULA_flags  <= it_flags;
        end
    end

    nrisc_ula_muldiv #(
        .TAM (TAM)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (eng_start),
        .op_div (ULA_ctrl == OP_DIV),
        .a      (ULA_A),
        .b      (ULA_B),
        .done   (eng_done),
        .lo     (eng_lo),
        .hi     (eng_hi),
        .dz     (eng_dz)
    );

endmodule

// File: tb/tb_nrisc_ula_seq.sv
// Self-checking bench for nrisc_ula_seq (TAM=16): directed vector table, handshake and
// reset sequences, and randomized ops scored against a behavioural model.
module tb_nrisc_ula_seq;
    import nrisc_ula_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ULA_A;
    logic [15:0] ULA_B;
    logic [3:0]  ULA_ctrl;
    logic [15:0] ULA_OUT;
    logic [15:0] ULA_OUT_HI;
    logic [3:0]  ULA_flags;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    logic [35:0] exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic [15:0] hi;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    nrisc_ula_seq #(.TAM(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ULA_A      (ULA_A),
        .ULA_B      (ULA_B),
        .ULA_ctrl   (ULA_ctrl),
        .ULA_OUT    (ULA_OUT),
        .ULA_OUT_HI (ULA_OUT_HI),
        .ULA_flags  (ULA_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: result packed as {out, hi, flags{V,N,Z,C}}
    function automatic logic [35:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        int          r;
        int          sr;
        int          n;
        longint      p;
        logic [15:0] out;
        logic [15:0] hi;
        logic        c;
        logic        v;
        logic        z;
        out = 16'h0;
        hi  = 16'h0;
        c   = 1'b0;
        v   = 1'b0;
        n   = int'(b[3:0]);
        case (op)
            OP_ADD: begin
                r   = int'(a) + int'(b);
                out = r[15:0];
                c   = (r > 65535);
                sr  = int'($signed(a)) + int'($signed(b));
                v   = (sr > 32767) || (sr < -32768);
            end
            OP_SUB: begin
                r   = int'(a) - int'(b);
                out = r[15:0];
                c   = (a < b);
                sr  = int'($signed(a)) - int'($signed(b));
                v   = (sr > 32767) || (sr < -32768);
            end
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_NOT: out = ~a;
            OP_SHR: begin
                out = a >> n;
                c   = (n == 0) ? 1'b0 : a[n-1];
            end
            OP_SHL: begin
                out = a << n;
                c   = (n == 0) ? 1'b0 : a[16-n];
            end
            OP_ROR: begin
                out = (n == 0) ? a : 16'((a >> n) | (a << (16 - n)));
                c   = (n == 0) ? 1'b0 : a[n-1];
            end
            OP_ROL: begin
                out = (n == 0) ? a : 16'((a << n) | (a >> (16 - n)));
                c   = (n == 0) ? 1'b0 : a[16-n];
            end
            OP_MUL: begin
                p   = longint'(a) * longint'(b);
                out = p[15:0];
                hi  = p[31:16];
                c   = (hi != 16'h0);
            end
            OP_DIV: begin
                if (b == 16'h0) begin
                    out = 16'hFFFF;
                    hi  = a;
                    c   = 1'b1;
                end else begin
                    out = 16'(int'(a) / int'(b));
                    hi  = 16'(int'(a) % int'(b));
                end
            end
            default: out = 16'h0;
        endcase
        z = (op == OP_MUL) ? (out == 16'h0 && hi == 16'h0) : (out == 16'h0);
        return {out, hi, v, out[15], z, c};
    endfunction

    // Driver: called at a falling edge; issues one op and returns at the falling edge
    // where out_valid is first seen, with the latency in clock edges since accept.
    task automatic issue_and_wait(input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, output int lat, output logic busy_rdy);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("issue_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        ULA_ctrl = op;
        ULA_A    = a;
        ULA_B    = b;
        @(negedge clk);
        in_valid = 1'b0;
        ULA_A    = 16'($urandom);
        ULA_B    = 16'($urandom);
        lat      = 1;
        busy_rdy = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_rdy = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    // Driver: consume the pending result
    task automatic pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        busy_rdy;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [35:0] e;
        int          exp_lat;

        vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b1100, 1};
        vecs[1]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0011, 1};
        vecs[2]  = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0101, 1};
        vecs[3]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b1000, 1};
        vecs[4]  = '{OP_ROL, 16'h8001, 16'h0001, 16'h0003, 16'h0000, 4'b0001, 1};
        vecs[5]  = '{OP_SHR, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 4'b0011, 1};
        vecs[6]  = '{OP_SHL, 16'h00F0, 16'h0000, 16'h00F0, 16'h0000, 4'b0000, 1};
        vecs[7]  = '{OP_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0001, 17};
        vecs[8]  = '{OP_DIV, 16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 17};
        vecs[9]  = '{OP_DIV, 16'h0055, 16'h0000, 16'hFFFF, 16'h0055, 4'b0101, 17};
        vecs[10] = '{4'b1010, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b0010, 1};
        vecs[11] = '{OP_NOT, 16'h0F0F, 16'h0000, 16'hF0F0, 16'h0000, 4'b0100, 1};
        vecs[12] = '{OP_ROR, 16'h0001, 16'h0001, 16'h8000, 16'h0000, 4'b0101, 1};
        vecs[13] = '{OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 4'b0000, 1};
        vecs[14] = '{OP_SHL, 16'h8001, 16'h0001, 16'h0002, 16'h0000, 4'b0001, 1};
        vecs[15] = '{OP_SHR, 16'h8000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0000, 1};

        // Reset
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ULA_A     = 16'h0;
        ULA_B     = 16'h0;
        ULA_ctrl  = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out", 32'(ULA_OUT), 32'd0);
        check("reset_out_hi", 32'(ULA_OUT_HI), 32'd0);
        check("reset_flags", 32'(ULA_flags), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            issue_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_rdy);
            check($sformatf("vec%0d_out", i), 32'(ULA_OUT), 32'(vecs[i].out));
            check($sformatf("vec%0d_hi", i), 32'(ULA_OUT_HI), 32'(vecs[i].hi));
            check($sformatf("vec%0d_flags", i), 32'(ULA_flags), 32'(vecs[i].flags));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_in_ready", i), 32'(busy_rdy), 32'd0);
            pop();
            check($sformatf("vec%0d_idle_after_pop", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: result held for 3 cycles with out_ready low
        issue_and_wait(OP_ADD, 16'h0001, 16'h0002, lat, busy_rdy);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out", 32'(ULA_OUT), 32'h0003);
            check("bp_flags", 32'(ULA_flags), 32'h0);
        end

        // Back-to-back: consume and accept a new op on the same edge
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ULA_ctrl  = OP_XOR;
        ULA_A     = 16'h00FF;
        ULA_B     = 16'h0F0F;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_out", 32'(ULA_OUT), 32'h0FF0);
        pop();

        // Reset during a multiply (5th busy cycle)
        in_valid = 1'b1;
        ULA_ctrl = OP_MUL;
        ULA_A    = 16'hFFFF;
        ULA_B    = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midop_busy_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out", 32'(ULA_OUT), 32'd0);
        check("midrst_out_hi", 32'(ULA_OUT_HI), 32'd0);
        check("midrst_flags", 32'(ULA_flags), 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_stale_valid", 32'(out_valid), 32'd0);

        // Randomized ops against the model
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (op == OP_DIV && $urandom_range(0, 5) == 0) b = 16'h0;
            else if (op == OP_DIV && $urandom_range(0, 1) == 1) b = 16'($urandom_range(1, 300));
            exp_lat = (op == OP_MUL || op == OP_DIV) ? 17 : 1;
            exp_q.push_back(model(op, a, b));
            issue_and_wait(op, a, b, lat, busy_rdy);
            e = exp_q.pop_front();
            check($sformatf("rnd%0d_op%0h_out", i, op), 32'(ULA_OUT), 32'(e[35:20]));
            check($sformatf("rnd%0d_op%0h_hi", i, op), 32'(ULA_OUT_HI), 32'(e[19:4]));
            check($sformatf("rnd%0d_op%0h_flags", i, op), 32'(ULA_flags), 32'(e[3:0]));
            check($sformatf("rnd%0d_op%0h_latency", i, op), 32'(lat), 32'(exp_lat));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check($sformatf("rnd%0d_hold", i), 32'(ULA_OUT), 32'(e[35:20]));
            pop();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
